clf_alf: RTL and testbench



---
 rtl/clf_alf.sv | 141 ++++++++++++++
 tb/tb_clf_alf.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/clf_alf.sv
// Combination lock with automatic re-lock: four key presses on active-low
// switches open the lock, which re-locks itself after AUTO_LOCK_CYCLES.
module clf_alf #(
    parameter int unsigned CODE0            = 0,
    parameter int unsigned CODE1            = 0,
    parameter int unsigned CODE2            = 2,
    parameter int unsigned CODE3            = 3,
    parameter int unsigned AUTO_LOCK_CYCLES = 20,
    parameter int unsigned ERR_CYCLES       = 4
) (
    output logic       sA,
    output logic       sB,
    output logic       sC,
    output logic       sD,
    output logic       sE,
    output logic       sF,
    output logic       sG,
    input  logic [7:0] sw,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int OPEN_W = (AUTO_LOCK_CYCLES > 1) ? $clog2(AUTO_LOCK_CYCLES) : 1;
    localparam int ERR_W  = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

    typedef enum logic [2:0] {
        LOCKED = 3'd0,
        GOT1   = 3'd1,
        GOT2   = 3'd2,
        GOT3   = 3'd3,
        OPEN   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    logic [7:0]        r_sync1, r_sync2, r_prev;
    state_t            r_state, w_state_nxt;
    logic [OPEN_W-1:0] r_open_cnt, w_open_cnt_nxt;
    logic [ERR_W-1:0]  r_err_cnt, w_err_cnt_nxt;

    logic [7:0] w_pressed;
    logic       w_event;
    logic       w_single;
    logic [2:0] w_idx;
    logic [6:0] w_seg;

    // Synchronizer plus "previous" stage; idle value is all-ones.
    // NOTE: every flop here uses <= so all stages sample the pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
            r_prev  <= 8'hFF;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Press event only on the idle-to-pressed transition, so a held key fires once.
    assign w_pressed = ~r_sync2;
    assign w_event   = (r_prev == 8'hFF) && (r_sync2 != 8'hFF);
    assign w_single  = ((w_pressed & (w_pressed - 8'd1)) == 8'd0);

    // NOTE: w_idx gets a default before the loop so no latch is inferred.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_pressed[i]) w_idx = i[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOCKED;
            r_open_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_open_cnt <= w_open_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_open_cnt_nxt = r_open_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        case (r_state)
            LOCKED, GOT1, GOT2, GOT3: begin
                if (w_event) begin
                    w_state_nxt   = ERROR;
                    w_err_cnt_nxt = '0;
                    if (w_single) begin
                        if (r_state == LOCKED && w_idx == CODE0[2:0]) w_state_nxt = GOT1;
                        if (r_state == GOT1   && w_idx == CODE1[2:0]) w_state_nxt = GOT2;
                        if (r_state == GOT2   && w_idx == CODE2[2:0]) w_state_nxt = GOT3;
                        if (r_state == GOT3   && w_idx == CODE3[2:0]) begin
                            w_state_nxt    = OPEN;
                            w_open_cnt_nxt = '0;
                        end
                    end
                end
            end
            OPEN: begin
                if (r_open_cnt == OPEN_W'(AUTO_LOCK_CYCLES - 1)) begin
                    w_state_nxt    = LOCKED;
                    w_open_cnt_nxt = '0;
                end else begin
                    w_open_cnt_nxt = r_open_cnt + OPEN_W'(1);
                end
            end
            ERROR: begin
                if (r_err_cnt == ERR_W'(ERR_CYCLES - 1)) begin
                    w_state_nxt   = LOCKED;
                    w_err_cnt_nxt = '0;
                end else begin
                    w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                end
            end
            default: w_state_nxt = LOCKED;
        endcase
    end

    // Active-low segments {a..g}, common anode.
    always_comb begin
        w_seg = 7'b1111111;
        case (r_state)
            LOCKED:  w_seg = 7'b1110001;
            GOT1:    w_seg = 7'b1001111;
            GOT2:    w_seg = 7'b0010010;
            GOT3:    w_seg = 7'b0000110;
            OPEN:    w_seg = 7'b1000001;
            ERROR:   w_seg = 7'b0110000;
            default: w_seg = 7'b1111111;
        endcase
    end

    assign {sA, sB, sC, sD, sE, sF, sG} = w_seg;

endmodule

// File: tb/tb_clf_alf.sv
// Bench for clf_alf: stimulus pushes expected display changes (value and edge
// number) into a queue; a monitor pops one entry per observed display change.
module tb_clf_alf;

    localparam logic [6:0] SEG_L = 7'b1110001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_U = 7'b1000001;
    localparam logic [6:0] SEG_E = 7'b0110000;

    typedef struct {
        logic [6:0] seg;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic       sA, sB, sC, sD, sE, sF, sG;
    logic [6:0] seg;

    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   mon_en;
    logic [6:0] last_seg;
    exp_t exp_q[$];

    clf_alf dut (
        .sA(sA), .sB(sB), .sC(sC), .sD(sD), .sE(sE), .sF(sF), .sG(sG),
        .sw(sw), .clk(clk), .rst_n(rst_n)
    );

    assign seg = {sA, sB, sC, sD, sE, sF, sG};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic push(input logic [6:0] s, input int c);
        exp_t e;
        e.seg = s;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a switch pattern, hold it, release to idle; up to two expected
    // display changes at fixed offsets from the drive cycle.
    task automatic press(input logic [7:0] val, input int hold, input int gap,
                         input int n, input logic [6:0] s1, input int d1,
                         input logic [6:0] s2, input int d2);
        int c;
        c = cyc;
        if (n > 0) push(s1, c + d1);
        if (n > 1) push(s2, c + d2);
        sw = val;
        tick(hold);
        sw = 8'hFF;
        tick(gap);
    endtask

    // Monitor: each display change must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && seg !== last_seg) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_change: got %b with nothing expected at cycle %0d",
                         seg, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("seg_value", int'(seg), int'(e.seg));
                check("seg_cycle", cyc, e.cyc);
            end
            last_seg = seg;
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        last_seg = SEG_L;
        sw       = 8'hFF;
        rst_n    = 1'b0;
        #30;
        check("reset_seg", int'(seg), int'(SEG_L));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(10);
        check("idle_seg", int'(seg), int'(SEG_L));

        // Correct code, then auto re-lock after exactly 20 cycles in OPEN
        press(8'hFE, 2, 3, 1, SEG_1, 3, SEG_L, 0);
        press(8'hFE, 2, 3, 1, SEG_2, 3, SEG_L, 0);
        press(8'hFB, 2, 3, 1, SEG_3, 3, SEG_L, 0);
        press(8'hF7, 2, 3, 2, SEG_U, 3, SEG_L, 23);
        // Press while open is ignored
        press(8'hFD, 2, 3, 0, SEG_L, 0, SEG_L, 0);
        tick(20);
        check("relocked_seg", int'(seg), int'(SEG_L));

        // Wrong key from LOCKED: 'E' for 4 cycles
        press(8'hFD, 2, 3, 2, SEG_E, 3, SEG_L, 7);
        tick(5);

        // Two keys together is an invalid press
        press(8'hFC, 2, 3, 2, SEG_E, 3, SEG_L, 7);
        tick(5);

        // Held key advances exactly once, then a wrong key errors out
        press(8'hFE, 20, 3, 1, SEG_1, 3, SEG_L, 0);
        press(8'hFD, 2, 3, 2, SEG_E, 3, SEG_L, 7);
        tick(5);

        // Three correct keys, then reset: sequence must restart
        press(8'hFE, 2, 3, 1, SEG_1, 3, SEG_L, 0);
        press(8'hFE, 2, 3, 1, SEG_2, 3, SEG_L, 0);
        press(8'hFB, 2, 3, 1, SEG_3, 3, SEG_L, 0);
        push(SEG_L, cyc);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        press(8'hF7, 2, 3, 2, SEG_E, 3, SEG_L, 7);
        tick(5);
        press(8'hFE, 2, 3, 1, SEG_1, 3, SEG_L, 0);
        press(8'hFE, 2, 3, 1, SEG_2, 3, SEG_L, 0);
        press(8'hFB, 2, 3, 1, SEG_3, 3, SEG_L, 0);
        press(8'hF7, 2, 3, 2, SEG_U, 3, SEG_L, 23);
        tick(30);

        check("pending_expectations", exp_q.size(), 0);
        check("final_seg", int'(seg), int'(SEG_L));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
